// File: rtl/buffet_fill_if.sv
// Bundle of fill-command, credit-return, AXI4-Lite read and buffet push signals for buffet_fill_ctrl.
// Handshake rule on every channel: a transfer happens on a rising clock edge where valid and ready are both high; once raised, valid and its payload stay put until that edge.
interface buffet_fill_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CREDIT_WIDTH = 8,
    parameter int LEN_WIDTH    = 16
);
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic                    cmd_valid;
    logic                    cmd_ready;

    logic [CREDIT_WIDTH-1:0] credit_in;
    logic                    credit_valid;
    logic                    credit_ready;

    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    logic [DATA_WIDTH-1:0]   push_data;
    logic                    push_data_valid;
    logic                    push_data_ready;

    modport master (
        input  cmd_addr, cmd_len, cmd_valid, credit_in, credit_valid,
               M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, push_data_ready,
        output cmd_ready, credit_ready, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
               M_AXI_RREADY, push_data, push_data_valid
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_valid, credit_in, credit_valid,
               M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, push_data_ready,
        input  cmd_ready, credit_ready, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
               M_AXI_RREADY, push_data, push_data_valid
    );
endinterface

// File: rtl/buffet_fill_ctrl.sv
// Credit-driven buffet fill engine: one AXI4-Lite read per buffet credit, each word pushed into the buffet.
// Define BUFFET_FILL_ERR_ABORT_EN to drop an errored word and end the command at once.
module buffet_fill_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CREDIT_WIDTH = 8,
    parameter int LEN_WIDTH    = 16,
    parameter int INIT_CREDITS = 255
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_ARESETN,
    buffet_fill_if.master         bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            state_dbg,
    output logic [CREDIT_WIDTH:0] credit_cnt_dbg
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, PUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0]   STRIDE   = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CREDIT_WIDTH:0]   INIT_CNT = (CREDIT_WIDTH + 1)'(INIT_CREDITS);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [DATA_WIDTH-1:0]   push_q;
    logic [CREDIT_WIDTH:0]   credit_cnt;

    logic                    ar_hs;
    logic                    credit_take;
    logic [CREDIT_WIDTH:0]   credit_add;
    logic [CREDIT_WIDTH:0]   credit_sub;

    // Outputs decode the state register; ARVALID is also gated by the registered credit count.
    assign bus.cmd_ready       = (state == IDLE);
    assign bus.M_AXI_ARVALID   = (state == ISSUE) && (credit_cnt != '0);
    assign bus.M_AXI_ARADDR    = cur_addr;
    assign bus.M_AXI_ARPROT    = 3'b000;
    assign bus.M_AXI_RREADY    = (state == WAIT_R);
    assign bus.push_data       = push_q;
    assign bus.push_data_valid = (state == PUSH);
    assign bus.credit_ready    = ~credit_cnt[CREDIT_WIDTH];
    assign busy                = (state != IDLE);
    assign done                = (state == DONE);
    assign state_dbg           = state;
    assign credit_cnt_dbg      = credit_cnt;

    assign ar_hs       = bus.M_AXI_ARVALID & bus.M_AXI_ARREADY;
    assign credit_take = bus.credit_valid & bus.credit_ready;
    assign credit_add  = credit_take ? {1'b0, bus.credit_in} : '0;
    assign credit_sub  = {{CREDIT_WIDTH{1'b0}}, ar_hs};

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            push_q     <= '0;
            error      <= 1'b0;
            credit_cnt <= INIT_CNT;
        end else begin
            // Credits flow in regardless of state; an AR handshake spends one.
            credit_cnt <= credit_cnt + credit_add - credit_sub;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cur_addr  <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        error     <= 1'b0;
                        state     <= (bus.cmd_len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (ar_hs) begin
                        cur_addr <= cur_addr + STRIDE;
                        state    <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (bus.M_AXI_RVALID) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (bus.M_AXI_RRESP != 2'b00) error <= 1'b1;
`ifdef BUFFET_FILL_ERR_ABORT_EN
                        if (bus.M_AXI_RRESP != 2'b00) begin
                            state <= DONE;
                        end else begin
                            push_q <= bus.M_AXI_RDATA;
                            state  <= PUSH;
                        end
`else
                        push_q <= bus.M_AXI_RDATA;
                        state  <= PUSH;
`endif
                    end
                end
                PUSH: begin
                    if (bus.push_data_ready) state <= (remaining == '0) ? DONE : ISSUE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
